// File: rtl/ws_array_feeder.sv
// Weight-stationary PE column feeder: loads one weight per row, then streams
// activation vectors with per-row skew and keeps the column enabled until psums drain.
module ws_array_feeder #(
    parameter int ROWS = 3,
    parameter int DW   = 10,
    parameter int CW   = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CW-1:0]        num_x,
    input  logic [DW-1:0]        w_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [ROWS*DW-1:0]   x_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic [ROWS*DW-1:0]   pe_win,
    output logic [ROWS-1:0]      pe_load_w,
    output logic [ROWS*DW-1:0]   pe_xin,
    output logic                 pe_enable,
    output logic                 busy,
    output logic                 done
);

    localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DCW = (2*ROWS-1 > 1) ? $clog2(2*ROWS-1) : 1;
    localparam logic [WCW-1:0] LAST_BEAT  = WCW'(ROWS-1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(2*ROWS-2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_num_x;
    logic [CW-1:0]        r_xcnt;
    logic [WCW-1:0]       r_wcnt;
    logic [DCW-1:0]       r_dcnt;
    logic [ROWS*DW-1:0]   r_win;
    logic [ROWS-1:0]      r_load_w;
    logic                 r_w_ready;
    logic                 r_x_ready;
    logic                 r_pe_enable;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_x_accept;
    logic                 w_x_last;
    logic [ROWS*DW-1:0]   w_inject;

    assign w_x_accept = x_valid & r_x_ready;
    // Compare one bit wider so num_x = 2^CW-1 never aliases to zero.
    assign w_x_last   = ({1'b0, r_xcnt} + 1'b1) == {1'b0, r_num_x};
    assign w_inject   = w_x_accept ? x_data : '0;

    // Control outputs are flops updated together with the state transition.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_x     <= '0;
            r_xcnt      <= '0;
            r_wcnt      <= '0;
            r_dcnt      <= '0;
            r_win       <= '0;
            r_load_w    <= '0;
            r_w_ready   <= 1'b0;
            r_x_ready   <= 1'b0;
            r_pe_enable <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: defaults first with <=; later assignments in this block win, giving one-cycle strobes.
            r_load_w <= '0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_x   <= num_x;
                        r_wcnt    <= '0;
                        r_w_ready <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        for (int k = 0; k < ROWS; k++) begin
                            if (r_wcnt == WCW'(k)) begin
                                r_win[k*DW +: DW] <= w_data;
                                r_load_w[k]       <= 1'b1;
                            end
                        end
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == LAST_BEAT) begin
                            r_w_ready <= 1'b0;
                            if (r_num_x != '0) begin
                                r_xcnt      <= '0;
                                r_x_ready   <= 1'b1;
                                r_pe_enable <= 1'b1;
                                r_state     <= S_STREAM;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_STREAM: begin
                    if (w_x_accept) begin
                        r_xcnt <= r_xcnt + 1'b1;
                        if (w_x_last) begin
                            r_x_ready <= 1'b0;
                            r_dcnt    <= '0;
                            r_state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_dcnt <= r_dcnt + 1'b1;
                    if (r_dcnt == LAST_DRAIN) begin
                        r_pe_enable <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Lane r is delayed by r+1 registers; zeros shift in whenever nothing is accepted.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DW-1:0] r_line [0:r];

        always_ff @(posedge sys_clk) begin
            if (rst) begin
                // NOTE: the skew registers are cleared on reset so an aborted pass leaves no data behind.
                for (int d = 0; d <= r; d++) begin
                    r_line[d] <= '0;
                end
            end else begin
                r_line[0] <= w_inject[r*DW +: DW];
                for (int d = 1; d <= r; d++) begin
                    r_line[d] <= r_line[d-1];
                end
            end
        end

        assign pe_xin[r*DW +: DW] = r_line[r];
    end

    assign w_ready   = r_w_ready;
    assign x_ready   = r_x_ready;
    assign pe_win    = r_win;
    assign pe_load_w = r_load_w;
    assign pe_enable = r_pe_enable;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ws_array_feeder.sv
// Self-checking bench for ws_array_feeder: each pass is planned up front, and a
// timeline model derives every expected output cycle by cycle from the plan.
module tb_ws_array_feeder;

    localparam int ROWS = 3;
    localparam int DW   = 10;
    localparam int CW   = 8;
    localparam int XW   = ROWS * DW;
    localparam int MAXC = 1024;

    logic            sys_clk;
    logic            rst;
    logic            start;
    logic [CW-1:0]   num_x;
    logic [DW-1:0]   w_data;
    logic            w_valid;
    logic            w_ready;
    logic [XW-1:0]   x_data;
    logic            x_valid;
    logic            x_ready;
    logic [XW-1:0]   pe_win;
    logic [ROWS-1:0] pe_load_w;
    logic [XW-1:0]   pe_xin;
    logic            pe_enable;
    logic            busy;
    logic            done;

    ws_array_feeder #(.ROWS(ROWS), .DW(DW), .CW(CW)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .start     (start),
        .num_x     (num_x),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .pe_win    (pe_win),
        .pe_load_w (pe_load_w),
        .pe_xin    (pe_xin),
        .pe_enable (pe_enable),
        .busy      (busy),
        .done      (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pass_id = 0;
    int cyc     = 0;

    // Per-pass stimulus plan and derived acceptance timeline.
    logic            wv   [MAXC];
    logic [DW-1:0]   wd   [MAXC];
    logic            xv   [MAXC];
    logic [XW-1:0]   xd   [MAXC];
    logic            st   [MAXC];
    logic [CW-1:0]   nx   [MAXC];
    int              beat_at [MAXC];
    logic            xacc [MAXC];
    logic [XW-1:0]   cur_win;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s pass=%0d cyc=%0d got=%0h expected=%0h", tag, pass_id, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_outputs(input logic e_busy, input logic e_wr, input logic e_xr,
                                  input logic e_en, input logic e_done,
                                  input logic [ROWS-1:0] e_load,
                                  input logic [XW-1:0] e_win, input logic [XW-1:0] e_xin);
        check("busy",      busy,      e_busy);
        check("w_ready",   w_ready,   e_wr);
        check("x_ready",   x_ready,   e_xr);
        check("pe_enable", pe_enable, e_en);
        check("done",      done,      e_done);
        check("pe_load_w", pe_load_w, e_load);
        check("pe_win",    pe_win,    e_win);
        check("pe_xin",    pe_xin,    e_xin);
    endtask

    // mode 0: random valids/data/start noise; mode 1: directed back-to-back skew;
    // mode 2: directed with one bubble between the two vectors.
    task automatic run_pass(input int num, input int mode, input bit do_abort);
        int k, lw, lx, n, done_c, end_c, abort_c, idx;
        logic [ROWS-1:0] e_load;
        logic [XW-1:0]   e_xin;
        pass_id++;
        for (int c = 0; c < MAXC; c++) begin
            wv[c] = (mode != 0) || ($urandom_range(0, 2) != 0) || (c % 3 == 0);
            xv[c] = (mode != 0) || ($urandom_range(0, 2) != 0) || (c % 3 == 0);
            wd[c] = DW'($urandom);
            xd[c] = XW'($urandom);
            st[c] = (mode == 0 && c > 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            nx[c] = CW'($urandom);
            beat_at[c] = 0;
            xacc[c] = 1'b0;
        end
        st[0] = 1'b1;
        nx[0] = CW'(num);
        if (mode != 0) begin
            for (int c = 1; c <= ROWS; c++) wd[c] = DW'(64 * c);
            xd[4] = {10'd3, 10'd2, 10'd1};
            if (mode == 1) begin
                xd[5] = {10'd6, 10'd5, 10'd4};
            end else begin
                xv[5] = 1'b0;
                xd[6] = {10'd6, 10'd5, 10'd4};
            end
        end

        // Timeline: weights accepted from cycle 1, vectors right after the last beat.
        k = 0;
        lw = 0;
        for (int c = 1; c < MAXC && lw == 0; c++) begin
            if (wv[c]) begin
                beat_at[c] = k + 1;
                if (k == ROWS - 1) lw = c;
                k++;
            end
        end
        lx = lw;
        n = 0;
        for (int c = lw + 1; c < MAXC && n < num; c++) begin
            if (xv[c]) begin
                xacc[c] = 1'b1;
                n++;
                lx = c;
            end
        end
        done_c  = (num > 0) ? lx + 2 * ROWS : lw + 1;
        end_c   = done_c + ROWS + 2;
        abort_c = do_abort ? lw + 2 : -1;
        for (int c = done_c + 1; c < MAXC; c++) st[c] = 1'b0;

        for (int c = 0; c <= end_c; c++) begin
            cyc = c;
            if (c > 0 && beat_at[c-1] != 0) cur_win[(beat_at[c-1]-1)*DW +: DW] = wd[c-1];
            if (c == abort_c + 1) begin
                cur_win = '0;
                expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
                rst = 1'b0;
                start = 1'b0;
                w_valid = 1'b0;
                x_valid = 1'b0;
                tick();
                cyc = c + 1;
                expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
                return;
            end
            e_load = '0;
            if (c > 0 && beat_at[c-1] != 0) e_load[beat_at[c-1]-1] = 1'b1;
            e_xin = '0;
            for (int r = 0; r < ROWS; r++) begin
                idx = c - 1 - r;
                if (idx >= 0 && xacc[idx]) e_xin[r*DW +: DW] = xd[idx][r*DW +: DW];
            end
            expect_outputs(c >= 1 && c <= done_c,
                           c >= 1 && c <= lw,
                           num > 0 && c > lw && c <= lx,
                           num > 0 && c > lw && c < lx + 2 * ROWS,
                           c == done_c,
                           e_load, cur_win, e_xin);
            rst     = (c == abort_c);
            start   = st[c];
            num_x   = nx[c];
            w_valid = wv[c];
            w_data  = wd[c];
            x_valid = xv[c];
            x_data  = xd[c];
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        num_x   = 8'd5;
        w_valid = 1'b1;
        w_data  = 10'h155;
        x_valid = 1'b1;
        x_data  = '1;
        cur_win = '0;

        tick();
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        cyc = 1;
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        rst     = 1'b0;
        start   = 1'b0;
        w_valid = 1'b0;
        x_valid = 1'b0;
        tick();
        cyc = 2;
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        run_pass(2, 1, 1'b0);
        run_pass(2, 2, 1'b0);
        run_pass(0, 0, 1'b0);
        run_pass(10, 0, 1'b1);
        run_pass(5, 0, 1'b0);
        for (int i = 0; i < 8; i++) run_pass($urandom_range(0, 12), 0, 1'b0);
        run_pass(255, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
